// File: rtl/dac_playback_ctrl.sv
// DAC waveform playback sequencer.
// Walks a CPU-loaded window of the waveform RAM through its registered read
// port. A programmable divider paces the samples, which go to the DAC over
// valid/ready. Supports one-shot and loop playback and keeps a sticky
// underrun flag for sample ticks that could not be serviced in time.
module dac_playback_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic                  cfg_loop,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH:0]   cfg_len,
    input  logic [DIV_WIDTH-1:0]  cfg_div,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] smp_data,
    output logic                  smp_valid,
    input  logic                  smp_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READ,
        S_WAIT,
        S_DRAIN
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE = 1;
    localparam logic [DIV_WIDTH-1:0]  CNT_ONE = 1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [DIV_WIDTH-1:0]    div_q, div_d;
    logic                    loop_q, loop_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [DIV_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    tick_pend_q, tick_pend_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   smp_data_q, smp_data_d;
    logic                    smp_valid_q, smp_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    underrun_q, underrun_d;

    logic accept;
    logic slot_free;
    logic tick;
    logic last_idx;

    // Handshake, divider tick and end-of-window decode shared by the next-state logic.
    always_comb begin
        accept    = smp_valid_q && smp_ready;
        slot_free = !smp_valid_q || smp_ready;
        // Ticks are irrelevant once the final one-shot sample is already loaded.
        tick      = busy_q && (state_q != S_DRAIN) && (cnt_q == div_q);
        last_idx  = ({1'b0, idx_q} == (len_q - LEN_ONE));
    end

    // Next-state computation for the sequencer, divider and output registers.
    // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        div_d       = div_q;
        loop_d      = loop_q;
        idx_d       = idx_q;
        tick_pend_d = tick_pend_q;
        ram_addr_d  = ram_addr_q;
        smp_data_d  = smp_data_q;
        smp_valid_d = smp_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        underrun_d  = underrun_q;
        cnt_d       = '0;

        if (busy_q) begin
            cnt_d = (cnt_q == div_q) ? '0 : cnt_q + CNT_ONE;
        end

        // At most one tick is remembered; a second one before service is an underrun.
        if (tick) begin
            tick_pend_d = 1'b1;
            if (tick_pend_q) begin
                underrun_d = 1'b1;
            end
        end

        if (accept) begin
            smp_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_start && !cfg_stop && (cfg_len != '0)) begin
                    base_d      = cfg_base;
                    len_d       = cfg_len;
                    div_d       = cfg_div;
                    loop_d      = cfg_loop;
                    idx_d       = '0;
                    cnt_d       = '0;
                    underrun_d  = 1'b0;
                    busy_d      = 1'b1;
                    // The start carries its own tick, consumed by this immediate first fetch.
                    tick_pend_d = 1'b0;
                    ram_addr_d  = cfg_base;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_READ;
            end
            S_READ: begin
                smp_data_d  = ram_dout;
                smp_valid_d = 1'b1;
                idx_d       = last_idx ? '0 : idx_q + IDX_ONE;
                state_d     = (last_idx && !loop_q) ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                // A tick arriving this cycle is serviced directly; a held one is consumed.
                if ((tick_pend_q || tick) && slot_free) begin
                    ram_addr_d  = base_q + idx_q;
                    tick_pend_d = tick_pend_q && tick;
                    state_d     = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (accept) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Stop aborts from any state; underrun is deliberately kept for software.
        if (cfg_stop) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            smp_valid_d = 1'b0;
            tick_pend_d = 1'b0;
            done_d      = 1'b0;
            cnt_d       = '0;
        end
    end

    // State and output registers, all cleared asynchronously.
    // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            div_q       <= '0;
            loop_q      <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            tick_pend_q <= 1'b0;
            ram_addr_q  <= '0;
            smp_data_q  <= '0;
            smp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            div_q       <= div_d;
            loop_q      <= loop_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            tick_pend_q <= tick_pend_d;
            ram_addr_q  <= ram_addr_d;
            smp_data_q  <= smp_data_d;
            smp_valid_q <= smp_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_we    = 1'b0;
    assign smp_data  = smp_data_q;
    assign smp_valid = smp_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign underrun  = underrun_q;

endmodule
